spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 193 +++++++++++++++++++
 tb/tb_spi_master.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI command master: shifts a 10-bit {cmd,din} word out MSB first, then either
// holds select for a tail (writes / address phases) or waits RD_LAT cycles and
// captures one byte from miso (read-data). A guaranteed deselect gap follows.
module spi_master #(
  parameter int unsigned RD_LAT   = 4,
  parameter int unsigned TAIL_CYC = 3,
  parameter int unsigned GAP_CYC  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] din,
  input  logic       miso,
  output logic       mosi,
  output logic       ss_n,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid
);

  localparam int unsigned WORD_W  = 10;
  localparam int unsigned BYTE_W  = 8;
  // Counter covers the longest phase: any parameter or the 9 shift steps after SETUP.
  localparam int unsigned MAX_A   = (RD_LAT > TAIL_CYC) ? RD_LAT : TAIL_CYC;
  localparam int unsigned MAX_B   = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
  localparam int unsigned MAX_CYC = (MAX_B > WORD_W) ? MAX_B : WORD_W;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT    = 3'd2,
    TAIL     = 3'd3,
    RD_WAIT  = 3'd4,
    RD_SHIFT = 3'd5,
    GAP      = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BYTE_W-1:0]   rx_q, rx_d;
  logic [BYTE_W-1:0]   rd_data_q, rd_data_d;
  logic                is_rd_q, is_rd_d;
  logic                mosi_q, mosi_d;
  logic                ss_n_q, ss_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rd_valid_q, rd_valid_d;
  logic                finish;

  // Next-state and next-output computation for the transaction sequencer.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    is_rd_d    = is_rd_q;
    mosi_d     = 1'b0;
    ss_n_d     = ss_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    finish     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !busy_q) begin
          sh_d    = {cmd, din};
          is_rd_d = (cmd == 2'b11);
          ss_n_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        mosi_d  = sh_q[WORD_W-1];
        sh_d    = {sh_q[WORD_W-2:0], 1'b0};
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        mosi_d = sh_q[WORD_W-1];
        sh_d   = {sh_q[WORD_W-2:0], 1'b0};
        if (cnt_q == CNT_W'(WORD_W - 2)) begin
          cnt_d = '0;
          if (is_rd_q) begin
            state_d = (RD_LAT == 0) ? RD_SHIFT : RD_WAIT;
          end else if (TAIL_CYC == 0) begin
            finish = 1'b1;
          end else begin
            state_d = TAIL;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TAIL: begin
        if (cnt_q == CNT_W'(TAIL_CYC - 1)) begin
          finish = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_WAIT: begin
        if (cnt_q == CNT_W'(RD_LAT - 1)) begin
          cnt_d   = '0;
          state_d = RD_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_SHIFT: begin
        // Eight capture edges, then one more edge publishes the whole byte.
        if (cnt_q == CNT_W'(BYTE_W)) begin
          rd_data_d  = rx_q;
          rd_valid_d = 1'b1;
          finish     = 1'b1;
        end else begin
          rx_d  = {rx_q[BYTE_W-2:0], miso};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        ss_n_d = 1'b1;
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Common end of transaction: deselect, pulse done, enter the gap.
    if (finish) begin
      ss_n_d = 1'b1;
      done_d = 1'b1;
      cnt_d  = '0;
      if (GAP_CYC == 0) begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end else begin
        state_d = GAP;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      cnt_q      <= '0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      is_rd_q    <= 1'b0;
      mosi_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      is_rd_q    <= is_rd_d;
      mosi_q     <= mosi_d;
      ss_n_q     <= ss_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign mosi     = mosi_q;
  assign ss_n     = ss_n_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a behavioural SPI slave + 256-byte RAM.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] din;
  logic       miso;
  logic       mosi;
  logic       ss_n;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       rd_valid;

  int total = 0;
  int bad   = 0;

  spi_master dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cmd      (cmd),
    .din      (din),
    .miso     (miso),
    .mosi     (mosi),
    .ss_n     (ss_n),
    .busy     (busy),
    .done     (done),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  // Slave model: negedge index 1 is the select-detect cycle, 2..11 carry the
  // command word, the word is decoded at 12, read byte bit 7 is driven at 15.
  int         scnt;
  logic [9:0] sword;
  logic [7:0] saddr;
  logic [7:0] slv_mem [256];

  always @(negedge clk) begin
    if (rst || ss_n) begin
      scnt <= 0;
      miso <= 1'b0;
    end else begin
      scnt <= scnt + 1;
      if (scnt >= 1 && scnt <= 10) sword <= {sword[8:0], mosi};
      if (scnt == 11) begin
        case (sword[9:8])
          2'b00, 2'b10: saddr <= sword[7:0];
          2'b01:        slv_mem[saddr] <= sword[7:0];
          default:      ;
        endcase
      end
      if (scnt >= 14 && scnt <= 21 && sword[9:8] == 2'b11)
        miso <= slv_mem[saddr][3'(21 - scnt)];
      else
        miso <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction to completion; reports whether busy stayed high too long.
  task automatic do_txn(input logic [1:0] c, input logic [7:0] d, output bit timed_out);
    start = 1'b1; cmd = c; din = d;
    tick();
    start = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cmd = 2'b00; din = 8'h00;
    tick(); tick(); tick();
    total++;
    if ({ss_n, mosi, busy, done, rd_valid} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_outputs: got ss_n,mosi,busy,done,rd_valid=%b expected 10000",
               {ss_n, mosi, busy, done, rd_valid});
    end
    total++;
    if (rd_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_rd_data: got %h expected 00", rd_data);
    end
    rst = 1'b0;
  endtask

  // Write address A5 with din scrambled every cycle after acceptance.
  task automatic test_write_addr();
    logic [9:0] exp_w;
    exp_w = {2'b00, 8'hA5};
    start = 1'b1; cmd = 2'b00; din = 8'hA5;
    tick();                                   // edge N (first edge after reset release)
    start = 1'b0; cmd = 2'b11;
    total++;
    if ({ss_n, busy, mosi} !== 3'b010) begin
      bad++;
      $display("FAIL wa_accept: got ss_n,busy,mosi=%b expected 010", {ss_n, busy, mosi});
    end
    for (int k = 1; k <= 10; k++) begin
      din = ~din ^ 8'(k);
      tick();                                 // edge N+k
      total++;
      if (mosi !== exp_w[10-k] || ss_n !== 1'b0) begin
        bad++;
        $display("FAIL wa_bit%0d: got mosi=%b ss_n=%b expected mosi=%b ss_n=0",
                 k, mosi, ss_n, exp_w[10-k]);
      end
    end
    tick(); tick();                           // N+12
    total++;
    if ({ss_n, done, mosi} !== 3'b000) begin
      bad++;
      $display("FAIL wa_tail: got ss_n,done,mosi=%b expected 000", {ss_n, done, mosi});
    end
    tick();                                   // N+13
    total++;
    if ({ss_n, done, busy} !== 3'b111) begin
      bad++;
      $display("FAIL wa_end: got ss_n,done,busy=%b expected 111", {ss_n, done, busy});
    end
    tick();                                   // N+14
    total++;
    if ({done, busy} !== 2'b01) begin
      bad++;
      $display("FAIL wa_gap: got done,busy=%b expected 01", {done, busy});
    end
    tick();                                   // N+15
    total++;
    if (busy !== 1'b0 || ss_n !== 1'b1) begin
      bad++;
      $display("FAIL wa_idle: got busy=%b ss_n=%b expected busy=0 ss_n=1", busy, ss_n);
    end
  endtask

  task automatic test_read_data();
    bit to;
    do_txn(2'b00, 8'h33, to);
    do_txn(2'b01, 8'h3C, to);
    do_txn(2'b10, 8'h33, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL rd_setup_timeout: got busy stuck expected idle");
    end
    start = 1'b1; cmd = 2'b11; din = 8'h00;
    tick();                                   // edge N
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      total++;
      if (mosi !== (k <= 2)) begin
        bad++;
        $display("FAIL rd_cmd_bit%0d: got %b expected %b", k, mosi, (k <= 2));
      end
    end
    for (int k = 11; k <= 22; k++) begin
      tick();
      total++;
      if ({ss_n, mosi, rd_valid, done} !== 4'b0000) begin
        bad++;
        $display("FAIL rd_wait_n%0d: got ss_n,mosi,rd_valid,done=%b expected 0000",
                 k, {ss_n, mosi, rd_valid, done});
      end
    end
    tick();                                   // N+23
    total++;
    if ({ss_n, rd_valid, done} !== 3'b111 || rd_data !== 8'h3C) begin
      bad++;
      $display("FAIL rd_end: got ss_n,rd_valid,done=%b rd_data=%h expected 111 3c",
               {ss_n, rd_valid, done}, rd_data);
    end
    tick();                                   // N+24
    total++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h3C) begin
      bad++;
      $display("FAIL rd_hold: got rd_valid=%b rd_data=%h expected 0 3c", rd_valid, rd_data);
    end
    tick();
  endtask

  // start held high: falls at 0, 16, 32; rises at 13, 29.
  task automatic test_back_to_back();
    int   falls [$];
    int   rises [$];
    logic prev;
    bit   to;
    prev = 1'b1;
    start = 1'b1; cmd = 2'b00; din = 8'h00;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (prev && !ss_n) falls.push_back(c);
      if (!prev && ss_n) rises.push_back(c);
      prev = ss_n;
    end
    start = 1'b0;
    total++;
    if (falls.size() != 3 || rises.size() != 2) begin
      bad++;
      $display("FAIL b2b_count: got falls=%0d rises=%0d expected 3 2", falls.size(), rises.size());
    end else begin
      total++;
      if (falls[1] - rises[0] != 3 || falls[2] - falls[1] != 16 || falls[0] != 0) begin
        bad++;
        $display("FAIL b2b_gap: got f0=%0d r0=%0d f1=%0d f2=%0d expected 0 13 16 32",
                 falls[0], rises[0], falls[1], falls[2]);
      end
    end
    do_txn(2'b00, 8'h00, to);                 // harmless drain if mid-flight
    for (int i = 0; i < 100 && busy; i++) tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain: got busy=%b expected 0", busy);
    end
  endtask

  // start pulses while busy and in the cycle busy falls are both dropped.
  task automatic test_busy_start();
    int seen;
    start = 1'b1; cmd = 2'b00; din = 8'h12;
    tick();                                   // N
    start = 1'b0;
    tick(); tick();                           // N+2
    start = 1'b1;
    tick();                                   // N+3
    start = 1'b0;
    for (int k = 4; k <= 14; k++) tick();     // N+14
    start = 1'b1;
    tick();                                   // N+15: busy falls here
    start = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL bs_busy_fall: got busy=%b expected 0", busy);
    end
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (ss_n !== 1'b1 || busy !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL bs_no_queue: got %0d active cycles expected 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    bit to;
    start = 1'b1; cmd = 2'b00; din = 8'hC3;
    tick();                                   // N
    start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    rst = 1'b1;
    tick();                                   // N+5
    total++;
    if ({ss_n, mosi, busy, done} !== 4'b1000 || rd_data !== 8'h00) begin
      bad++;
      $display("FAIL rm_abort: got ss_n,mosi,busy,done=%b rd_data=%h expected 1000 00",
               {ss_n, mosi, busy, done}, rd_data);
    end
    rst = 1'b0; start = 1'b1; cmd = 2'b00; din = 8'h10;
    tick();                                   // N+6: first edge after reset
    start = 1'b0;
    total++;
    if ({ss_n, busy} !== 2'b01) begin
      bad++;
      $display("FAIL rm_restart: got ss_n,busy=%b expected 01", {ss_n, busy});
    end
    pulses = 0;
    for (int k = 0; k < 11; k++) begin
      tick();
      if (done || rd_valid) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL rm_no_done: got %0d pulses expected 0", pulses);
    end
    for (int i = 0; i < 100 && busy; i++) tick();
    to = busy;
    total++;
    if (to) begin
      bad++;
      $display("FAIL rm_timeout: got busy=1 expected 0");
    end
  endtask

  task automatic test_integration();
    bit t0, t1, t2, t3;
    do_txn(2'b00, 8'h10, t0);
    do_txn(2'b01, 8'h77, t1);
    do_txn(2'b10, 8'h10, t2);
    do_txn(2'b11, 8'hFF, t3);
    total++;
    if (t0 || t1 || t2 || t3) begin
      bad++;
      $display("FAIL int_timeout: got timeouts=%b%b%b%b expected 0000", t0, t1, t2, t3);
    end
    total++;
    if (rd_data !== 8'h77) begin
      bad++;
      $display("FAIL int_rd_data: got %h expected 77", rd_data);
    end
    do_txn(2'b10, 8'h33, t0);
    do_txn(2'b11, 8'h00, t1);
    total++;
    if (rd_data !== 8'h3C || t0 || t1) begin
      bad++;
      $display("FAIL int_rd_other: got %h expected 3c", rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_write_addr();
    test_read_data();
    test_back_to_back();
    test_busy_start();
    test_reset_mid();
    test_integration();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
